notification_scheduler: RTL

Sequential controller for the 8:1 notification selector (`notification_mux`). It latches per-app notification pulses into a pending register and drives that register onto the mux data input. It steps the mux select round-robin, reading the mux output to find the next pending app, then presents the winning app index on a valid/ready interface. The pending bit is cleared when the consumer accepts the index. The mux stays outside this block; the block owns its `a` and `s` inputs and consumes its `y`.

---
 rtl/notif_pkg.sv | 32 +++
 rtl/notification_mux.sv | 12 +
 rtl/notification_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/notif_pkg.sv
// Shared definitions for the notification scheduler and its 8:1 selector.
package notif_pkg;

  localparam int N_APPS = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] APP_WHATSAPP = 3'd0;
  localparam logic [SEL_W-1:0] APP_LINKEDIN = 3'd1;
  localparam logic [SEL_W-1:0] APP_GMAIL    = 3'd2;
  localparam logic [SEL_W-1:0] APP_SMS      = 3'd3;
  localparam logic [SEL_W-1:0] APP_YOUTUBE  = 3'd4;
  localparam logic [SEL_W-1:0] APP_FACEBOOK = 3'd5;
  localparam logic [SEL_W-1:0] APP_CALENDAR = 3'd6;
  localparam logic [SEL_W-1:0] APP_CALLS    = 3'd7;

  // Number of set bits in an 8-bit vector (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/notification_mux.sv
// 8:1 notification selector: y = a[s]. Lives beside the scheduler, not inside it.
module notification_mux
  import notif_pkg::*;
(
  input  logic [N_APPS-1:0] a,
  input  logic [SEL_W-1:0]  s,
  output logic              y
);

  assign y = a[s];

endmodule

// File: rtl/notification_scheduler.sv
// Round-robin notification scheduler. Latches per-app pulses into a pending
// register, walks the external mux select to find the next pending app and
// presents its index on a valid/ready port.
module notification_scheduler
  import notif_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_APPS-1:0] notif_in,
  input  logic              clear_all,
  output logic [N_APPS-1:0] mux_a,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_y,
  output logic              out_valid,
  output logic [SEL_W-1:0]  out_app,
  input  logic              out_ready,
  output logic [3:0]        pend_cnt,
  output logic [CNT_W-1:0]  coalesced
);

  state_t             r_state;
  logic [N_APPS-1:0]  r_pending;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_probe;
  logic               r_out_valid;
  logic [SEL_W-1:0]   r_out_app;
  logic [CNT_W-1:0]   r_coalesced;

  logic               w_accept;
  logic [N_APPS-1:0]  w_acc_mask;
  logic [N_APPS-1:0]  w_clr_mask;
  logic [N_APPS-1:0]  w_pending_next;
  logic               w_collide;
  logic [SEL_W-1:0]   w_app_inc;

  assign w_accept   = r_out_valid & out_ready;
  assign w_acc_mask = w_accept ? (N_APPS'(1) << r_out_app) : '0;
  assign w_clr_mask = {N_APPS{clear_all}};
  // New pulses always win over both kinds of clear.
  assign w_pending_next = notif_in | (r_pending & ~w_clr_mask & ~w_acc_mask);
  assign w_collide  = |(notif_in & r_pending);
  // Index arithmetic wraps 7 -> 0 by width.
  assign w_app_inc  = r_out_app + SEL_W'(1);

  // Pending register and saturating coalesce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_coalesced <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_collide && (r_coalesced != {CNT_W{1'b1}})) begin
        r_coalesced <= r_coalesced + CNT_W'(1);
      end
    end
  end

  // Scan/present state machine; the probe register doubles as the mux select,
  // since it already equals out_app while an index is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_probe     <= '0;
      r_out_valid <= 1'b0;
      r_out_app   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_state <= SCAN;
            r_probe <= r_ptr;
          end
        end
        SCAN: begin
          if (w_pending_next == '0) begin
            r_state <= IDLE;
          end else if (mux_y) begin
            r_out_app   <= r_probe;
            r_out_valid <= 1'b1;
            r_state     <= PRESENT;
          end else begin
            r_probe <= r_probe + SEL_W'(1);
          end
        end
        PRESENT: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_ptr       <= w_app_inc;
            if (w_pending_next != '0) begin
              r_state <= SCAN;
              r_probe <= w_app_inc;
            end else begin
              r_state <= IDLE;
            end
          end else if (clear_all) begin
            // Withdrawal: drop valid, keep the round-robin pointer.
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mux_a     = r_pending;
  assign mux_sel   = r_probe;
  assign out_valid = r_out_valid;
  assign out_app   = r_out_app;
  assign pend_cnt  = popcount8(r_pending);
  assign coalesced = r_coalesced;

endmodule
